// File: rtl/hazard_pkg.sv
// Shared types and sizing for the decode-stage register-dependency scoreboard.
package hazard_pkg;
  localparam int REG_ADDR_W   = 5;
  localparam int NUM_REGS     = 32;
  localparam int MAX_INFLIGHT = 3;
  localparam int SB_CNT_W     = $clog2(MAX_INFLIGHT + 1);

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [SB_CNT_W-1:0]   sb_cnt_t;

  localparam sb_cnt_t CNT_MAX = sb_cnt_t'(MAX_INFLIGHT);
endpackage

// File: rtl/sb_counter.sv
// Pending-write counter for one architectural register: saturating up/down,
// with an underflow strobe when a retire arrives while nothing is pending.
module sb_counter
  import hazard_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                inc,
  input  logic                dec,
  output logic [SB_CNT_W-1:0] cnt,
  output logic                underflow
);

  sb_cnt_t cnt_reg;
  sb_cnt_t cnt_next;

  // A simultaneous issue and retire on the same register cancel out.
  always_comb begin
    cnt_next = cnt_reg;
    if (inc && !dec && cnt_reg != CNT_MAX) begin
      cnt_next = cnt_reg + sb_cnt_t'(1);
    end else if (dec && !inc && cnt_reg != '0) begin
      cnt_next = cnt_reg - sb_cnt_t'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign cnt       = cnt_reg;
  assign underflow = dec && (cnt_reg == '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard scoreboard: per-register pending-write counts drive PC/IF-ID stalls
// and ID/EX bubbles. Optional macro SB_WB_BYPASS_EN lets a source read through a same-cycle writeback.
module hazard_scoreboard
  import hazard_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_rd_wen,
  input  logic                  flush,
  input  logic                  wb_wen,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  output logic                  stall_pc,
  output logic                  stall_id,
  output logic                  bubble_ex,
  output logic                  sb_err
);

  sb_cnt_t             cnt_arr [NUM_REGS];
  logic [NUM_REGS-1:1] inc_vec;
  logic [NUM_REGS-1:1] dec_vec;
  logic [NUM_REGS-1:1] underflow_vec;
  logic                hazard;
  logic                issue;
  logic                rs1_blk;
  logic                rs2_blk;
  logic                waw_blk;
  logic                rs1_byp;
  logic                rs2_byp;
  logic                sb_err_reg;

  assign cnt_arr[0] = '0;

  generate
    for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_cnt
      assign inc_vec[gi] = issue && id_rd_wen && (id_rd == reg_addr_t'(gi));
      assign dec_vec[gi] = wb_wen && (wb_rd == reg_addr_t'(gi));

      sb_counter u_cnt (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .inc       (inc_vec[gi]),
        .dec       (dec_vec[gi]),
        .cnt       (cnt_arr[gi]),
        .underflow (underflow_vec[gi])
      );
    end
  endgenerate

`ifdef SB_WB_BYPASS_EN
  // Last pending write retiring this cycle: the register file writes before it is read.
  assign rs1_byp = wb_wen && (wb_rd == id_rs1) && (cnt_arr[id_rs1] == sb_cnt_t'(1));
  assign rs2_byp = wb_wen && (wb_rd == id_rs2) && (cnt_arr[id_rs2] == sb_cnt_t'(1));
`else
  assign rs1_byp = 1'b0;
  assign rs2_byp = 1'b0;
`endif

  assign rs1_blk = id_rs1_used && (id_rs1 != '0) && (cnt_arr[id_rs1] != '0) && !rs1_byp;
  assign rs2_blk = id_rs2_used && (id_rs2 != '0) && (cnt_arr[id_rs2] != '0) && !rs2_byp;
  assign waw_blk = id_rd_wen && (id_rd != '0) && (cnt_arr[id_rd] == CNT_MAX);

  assign hazard    = id_valid && (rs1_blk || rs2_blk || waw_blk);
  assign issue     = id_valid && !hazard && !flush;
  assign stall_pc  = hazard && !flush;
  assign stall_id  = hazard && !flush;
  assign bubble_ex = hazard || flush;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      sb_err_reg <= 1'b0;
    end else if (|underflow_vec) begin
      sb_err_reg <= 1'b1;
    end
  end

  assign sb_err = sb_err_reg;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench for hazard_scoreboard; honours SB_WB_BYPASS_EN for the RAW penalty.
module tb_hazard_scoreboard;
  import hazard_pkg::*;

  logic      clk;
  logic      rst_n;
  logic      id_valid;
  reg_addr_t id_rs1, id_rs2, id_rd, wb_rd;
  logic      id_rs1_used, id_rs2_used, id_rd_wen;
  logic      flush, wb_wen;
  logic      stall_pc, stall_id, bubble_ex, sb_err;

  int checks   = 0;
  int failures = 0;

`ifdef SB_WB_BYPASS_EN
  localparam int RAW_PENALTY = 2;
`else
  localparam int RAW_PENALTY = 3;
`endif

  hazard_scoreboard dut (
    .i_clk       (clk),
    .i_rst       (rst_n),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rs1_used (id_rs1_used),
    .id_rs2_used (id_rs2_used),
    .id_rd       (id_rd),
    .id_rd_wen   (id_rd_wen),
    .flush       (flush),
    .wb_wen      (wb_wen),
    .wb_rd       (wb_rd),
    .stall_pc    (stall_pc),
    .stall_id    (stall_id),
    .bubble_ex   (bubble_ex),
    .sb_err      (sb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
    id_rd = 0; id_rd_wen = 0; flush = 0; wb_wen = 0; wb_rd = 0;
  endtask

  task automatic check_cnt(input string name, input int r, input int exp);
    checks++;
    if (int'(dut.cnt_arr[r]) !== exp) begin
      failures++;
      $display("FAIL %s: cnt[%0d] got %0d expected %0d", name, r, dut.cnt_arr[r], exp);
    end else
      $display("ok   %s: cnt[%0d]=%0d", name, r, exp);
  endtask

  task automatic test_reset();
    int nz;
    idle_inputs();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({stall_pc, stall_id, bubble_ex, sb_err} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_idle: stall_pc/stall_id/bubble_ex/sb_err got %b expected 0000",
               {stall_pc, stall_id, bubble_ex, sb_err});
    end else
      $display("ok   reset_idle: outputs 0000");
    flush = 1;
    #1;
    checks++;
    if ({stall_pc, bubble_ex} !== 2'b01) begin
      failures++;
      $display("FAIL reset_flush: stall_pc,bubble_ex got %b expected 01", {stall_pc, bubble_ex});
    end else
      $display("ok   reset_flush: bubble_ex follows flush");
    flush = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    nz = 0;
    for (int r = 0; r < NUM_REGS; r++) if (dut.cnt_arr[r] != '0) nz++;
    checks++;
    if (nz !== 0 || stall_pc !== 1'b0 || sb_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_counters: nonzero counters %0d stall_pc %b sb_err %b expected 0 0 0",
               nz, stall_pc, sb_err);
    end else
      $display("ok   reset_counters: all zero");
  endtask

  task automatic test_back_to_back();
    int stalls;
    bit issued;
    // Producer writes x5 in cycle 0; it reaches writeback in cycle 3.
    @(negedge clk);
    idle_inputs();
    id_valid = 1; id_rd = 5; id_rd_wen = 1;
    #1;
    checks++;
    if (stall_pc !== 1'b0) begin
      failures++;
      $display("FAIL raw_producer: stall_pc got %b expected 0", stall_pc);
    end else
      $display("ok   raw_producer: issued");
    stalls = 0;
    issued = 0;
    for (int c = 1; c <= 8 && !issued; c++) begin
      @(negedge clk);
      idle_inputs();
      id_valid = 1; id_rs1 = 5; id_rs1_used = 1;
      wb_wen = (c == 3); wb_rd = 5;
      #1;
      checks++;
      if (bubble_ex !== stall_pc || stall_id !== stall_pc) begin
        failures++;
        $display("FAIL raw_cycle%0d: stall_pc %b stall_id %b bubble_ex %b expected all equal",
                 c, stall_pc, stall_id, bubble_ex);
      end
      if (stall_pc) stalls++;
      else issued = 1;
    end
    checks++;
    if (!issued || stalls !== RAW_PENALTY) begin
      failures++;
      $display("FAIL raw_penalty: stall cycles got %0d (issued=%0b) expected %0d",
               stalls, issued, RAW_PENALTY);
    end else
      $display("ok   raw_penalty: %0d stall cycles", stalls);
    @(negedge clk);
    idle_inputs();
    check_cnt("raw_retired", 5, 0);
  endtask

  task automatic test_x0();
    @(negedge clk);
    idle_inputs();
    id_valid = 1; id_rd = 0; id_rd_wen = 1;
    #1;
    checks++;
    if (stall_pc !== 1'b0) begin
      failures++;
      $display("FAIL x0_write: stall_pc got %b expected 0", stall_pc);
    end else
      $display("ok   x0_write: no stall");
    @(negedge clk);
    idle_inputs();
    id_valid = 1; id_rs1 = 0; id_rs1_used = 1; id_rs2 = 0; id_rs2_used = 1;
    #1;
    checks++;
    if (stall_pc !== 1'b0 || bubble_ex !== 1'b0) begin
      failures++;
      $display("FAIL x0_read: stall_pc %b bubble_ex %b expected 0 0", stall_pc, bubble_ex);
    end else
      $display("ok   x0_read: no stall");
    check_cnt("x0_cnt", 0, 0);
  endtask

  task automatic test_waw();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      idle_inputs();
      id_valid = 1; id_rd = 7; id_rd_wen = 1;
      #1;
      checks++;
      if (stall_pc !== 1'b0) begin
        failures++;
        $display("FAIL waw_issue%0d: stall_pc got %b expected 0", k, stall_pc);
      end else
        $display("ok   waw_issue%0d: issued", k);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      idle_inputs();
      id_valid = 1; id_rd = 7; id_rd_wen = 1;
      wb_wen = (c == 2); wb_rd = 7;
      #1;
      checks++;
      if (stall_pc !== 1'b1 || bubble_ex !== 1'b1) begin
        failures++;
        $display("FAIL waw_block%0d: stall_pc %b bubble_ex %b expected 1 1", c, stall_pc, bubble_ex);
      end else
        $display("ok   waw_block%0d: stalled", c);
    end
    @(negedge clk);
    idle_inputs();
    id_valid = 1; id_rd = 7; id_rd_wen = 1;
    #1;
    checks++;
    if (stall_pc !== 1'b0) begin
      failures++;
      $display("FAIL waw_release: stall_pc got %b expected 0", stall_pc);
    end else
      $display("ok   waw_release: fourth writer issued");
    @(negedge clk);
    idle_inputs();
    check_cnt("waw_full", 7, 3);
    for (int k = 0; k < 3; k++) begin
      wb_wen = 1; wb_rd = 7;
      @(negedge clk);
    end
    idle_inputs();
    check_cnt("waw_drained", 7, 0);
  endtask

  task automatic test_simul_flush();
    @(negedge clk);
    idle_inputs();
    id_valid = 1; id_rd = 3; id_rd_wen = 1;
    @(negedge clk);
    idle_inputs();
    check_cnt("simul_pre", 3, 1);
    id_valid = 1; id_rd = 3; id_rd_wen = 1; wb_wen = 1; wb_rd = 3;
    #1;
    checks++;
    if (stall_pc !== 1'b0) begin
      failures++;
      $display("FAIL simul_issue: stall_pc got %b expected 0", stall_pc);
    end else
      $display("ok   simul_issue: issued with same-register writeback");
    @(negedge clk);
    idle_inputs();
    check_cnt("simul_post", 3, 1);
    id_valid = 1; id_rs1 = 3; id_rs1_used = 1; id_rd = 4; id_rd_wen = 1; flush = 1;
    #1;
    checks++;
    if ({stall_pc, stall_id, bubble_ex} !== 3'b001) begin
      failures++;
      $display("FAIL flush_hazard: stall_pc/stall_id/bubble_ex got %b expected 001",
               {stall_pc, stall_id, bubble_ex});
    end else
      $display("ok   flush_hazard: bubble only");
    @(negedge clk);
    flush = 0;
    #1;
    checks++;
    if ({stall_pc, stall_id, bubble_ex} !== 3'b111) begin
      failures++;
      $display("FAIL hazard_noflush: stall_pc/stall_id/bubble_ex got %b expected 111",
               {stall_pc, stall_id, bubble_ex});
    end else
      $display("ok   hazard_noflush: stalled");
    idle_inputs();
    #1;
    check_cnt("flush_cnt3", 3, 1);
    check_cnt("flush_cnt4", 4, 0);
    wb_wen = 1; wb_rd = 3;
    @(negedge clk);
    idle_inputs();
    check_cnt("simul_drained", 3, 0);
  endtask

  task automatic test_underflow();
    @(negedge clk);
    idle_inputs();
    wb_wen = 1; wb_rd = 0;
    @(negedge clk);
    idle_inputs();
    checks++;
    if (sb_err !== 1'b0) begin
      failures++;
      $display("FAIL wb_x0: sb_err got %b expected 0", sb_err);
    end else
      $display("ok   wb_x0: no error");
    wb_wen = 1; wb_rd = 9;
    @(negedge clk);
    idle_inputs();
    checks++;
    if (sb_err !== 1'b1) begin
      failures++;
      $display("FAIL underflow_set: sb_err got %b expected 1", sb_err);
    end else
      $display("ok   underflow_set: sb_err raised");
    check_cnt("underflow_cnt", 9, 0);
    repeat (3) @(negedge clk);
    checks++;
    if (sb_err !== 1'b1) begin
      failures++;
      $display("FAIL underflow_sticky: sb_err got %b expected 1", sb_err);
    end else
      $display("ok   underflow_sticky: sb_err held");
    rst_n = 1'b0;
    #1;
    checks++;
    if (sb_err !== 1'b0) begin
      failures++;
      $display("FAIL underflow_clear: sb_err got %b expected 0", sb_err);
    end else
      $display("ok   underflow_clear: cleared by reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset_midop();
    @(negedge clk);
    idle_inputs();
    id_valid = 1; id_rd = 12; id_rd_wen = 1;
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    #1;
    check_cnt("reset_midop", 12, 0);
    @(negedge clk);
    rst_n = 1'b1;
    id_valid = 1; id_rs1 = 12; id_rs1_used = 1;
    #1;
    checks++;
    if (stall_pc !== 1'b0) begin
      failures++;
      $display("FAIL reset_midop_read: stall_pc got %b expected 0", stall_pc);
    end else
      $display("ok   reset_midop_read: no stale dependency");
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_x0();
    test_waw();
    test_simul_flush();
    test_underflow();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Register-dependency scoreboard for the non-forwarding pipeline, sitting in decode directly upstream of the PC register and the IF/ID register. It tracks how many issued but not yet written-back writes target each architectural register, and asserts the stalls that freeze the PC and IF/ID and insert a bubble into ID/EX. Operand reads do not proceed until every pending write to that operand has retired through writeback.

## Interface
- NUM_REGS, 32: architectural register count; register 0 is hard-wired zero and never tracked.
- MAX_INFLIGHT, 3: maximum pending writes per register, matching the EX/MEM/WB depth; counter width is clog2(MAX_INFLIGHT+1).
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  reset, asynchronous, active-low.
- id_valid  in  1  decode holds a real instruction.
- id_rs1, id_rs2  in  5 each  source register addresses.
- id_rs1_used, id_rs2_used  in  1 each  source is actually read.
- id_rd  in  5  destination register.
- id_rd_wen  in  1  instruction writes id_rd.
- flush  in  1  branch/jump taken in EX; the decode instruction is squashed this cycle.
- wb_wen  in  1  writeback commits this cycle.
- wb_rd  in  5  writeback destination.
- stall_pc  out  1  hold the PC.
- stall_id  out  1  hold IF/ID.
- bubble_ex  out  1  load a NOP into ID/EX.
- sb_err  out  1  sticky flag: writeback seen with zero pending count.

## Operation
- Per-register pending counter cnt[r], r = 1..NUM_REGS-1. cnt[0] reads as 0 permanently.
- A source is blocked when it is used, its address is nonzero, and cnt[addr] != 0 (refined by the macro below).
- A WAW block applies when id_rd_wen, id_rd != 0 and cnt[id_rd] == MAX_INFLIGHT.
- hazard = id_valid & (rs1 blocked | rs2 blocked | WAW block).
- stall_pc = stall_id = hazard & ~flush.
- bubble_ex = hazard | flush.
- issue = id_valid & ~hazard & ~flush.
- Increment cnt[id_rd] on issue & id_rd_wen & id_rd != 0.
- Decrement cnt[wb_rd] on wb_wen & wb_rd != 0.
- Increment and decrement of the same register in the same cycle leave it unchanged.
- Increments and decrements to different registers update independently.
- A decrement at cnt == 0 holds at 0 and sets sb_err. sb_err clears only on reset.
- Flush never modifies counters. Already-issued instructions still write back and retire their counts.

## Timing
- Counters and sb_err are registered. stall_pc, stall_id and bubble_ex are combinational from the counters and the ID/WB inputs, with zero-cycle latency to the PC and IF/ID enables.
- A counter update made at edge N is visible to the hazard logic in cycle N+1.
- On reset (async assert): all counters = 0 and sb_err = 0. Therefore stall_pc = 0, stall_id = 0, and bubble_ex = flush.
- Reset asserted mid-operation discards all pending counts immediately; there is no drain.
- Without the macro, the RAW penalty for back-to-back dependent instructions is 3 stall cycles. The dependent instruction issues in the cycle after the producer's writeback edge.

## Configuration
- SB_WB_BYPASS_EN defined:
  - A source whose register has cnt == 1 and matches wb_rd with wb_wen in the same cycle is not blocked. This relies on the register file's write-before-read.
  - Penalty drops to 2 cycles.
- Undefined: a source is blocked while its cnt is nonzero, with no exception for a same-cycle writeback.

## Structure
- Package hazard_pkg holds:
  - REG_ADDR_W = 5
  - NUM_REGS
  - MAX_INFLIGHT
  - SB_CNT_W
  - typedef reg_addr_t
  - typedef sb_cnt_t
- Sub-module sb_counter: one saturating up/down counter with inc, dec and underflow output. It is instantiated in a generate loop for registers 1..NUM_REGS-1.
- The top level holds the hazard compare, the issue logic and the sb_err OR-reduction.

## Test plan
- Reset then idle:
  - Stimulus: id_valid = 0.
  - Required: stall_pc = 0, bubble_ex = 0, all cnt = 0, sb_err = 0.
- Back-to-back RAW:
  - Stimulus: issue writing x5, then a consumer with rs1 = x5, with writeback 3 cycles after issue.
  - Required without macro: stall_pc high 3 cycles.
  - Required with SB_WB_BYPASS_EN: stall_pc high 2 cycles.
- x0 write:
  - Stimulus: id_rd = 0, id_rd_wen = 1; next instruction has rs1 = 0.
  - Required: no counter change, no stall.
- WAW saturation:
  - Stimulus: three issues writing x7 with no writeback, then a fourth writer to x7.
  - Required: stall_pc = 1 until one wb_rd = 7 commits.
- Simultaneous events and flush:
  - Stimulus: issue writing x3 while wb_rd = 3 commits, then flush during a hazard.
  - Required: cnt[3] unchanged; stall_pc = 0 and bubble_ex = 1 during the flush.
- Underflow:
  - Stimulus: wb_wen with wb_rd = 9 while cnt[9] = 0.
  - Required: cnt[9] stays 0; sb_err = 1 and stays set until i_rst asserts.
